serial_addsub16_ctrl: RTL and testbench

Multi-cycle 16-bit adder/subtractor built around a single 4-bit ripple add/sub slice that is reused once per nibble. The controller latches both operands, steps the slice through nibbles 0..3 LSB-first, and chains the carry through a register between passes. It presents a start/busy/done handshake to the surrounding datapath and holds the 16-bit result, carry and overflow until the next accepted start.

---
 rtl/serial_addsub16_ctrl.sv | 172 +++++++++++++++++
 tb/tb_serial_addsub16_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub16_ctrl.sv
// serial_addsub16_ctrl
//
// Multi-cycle 16-bit adder/subtractor. A single 4-bit add/sub slice is reused
// once per nibble, LSB nibble first. The carry between passes is held in a
// register, so a full operation takes four RUN cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request; only sampled while idle
//   op         0 = a + b, 1 = a - b (sampled with start)
//   a, b       16-bit operands (sampled with start)
//   busy       high while an operation is running or completing
//   done       one-cycle pulse when result/carry_out/overflow are valid
//   result     16-bit sum or difference, mod 2^16
//   carry_out  carry out of bit 15 (for subtract: 1 = no borrow)
//   overflow   two's-complement overflow of the full 16-bit operation

// 4-bit add/sub slice. b is inverted when sub is set, and the caller supplies
// the carry-in: op for the first nibble, the registered carry afterwards.
module addsub4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovf
);

  logic [3:0] b_x;
  logic [4:0] sum_wide;

  always_comb begin
    b_x      = b ^ {4{sub}};
    sum_wide = {1'b0, a} + {1'b0, b_x} + {4'b0000, cin};
    sum      = sum_wide[3:0];
    cout     = sum_wide[4];
    // Only meaningful on the top nibble: same-sign inputs whose sum flips sign.
    ovf      = (a[3] == b_x[3]) && (sum_wide[3] != a[3]);
  end

endmodule

module serial_addsub16_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic        op_reg;
  logic [1:0]  nib_cnt;
  logic        carry_reg;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic        slice_cin;
  logic [3:0]  slice_sum;
  logic        slice_cout;
  logic        slice_ovf;

  // Route the current nibble of the latched operands into the shared slice.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    case (nib_cnt)
      2'd0: begin a_nib = a_reg[3:0];   b_nib = b_reg[3:0];   end
      2'd1: begin a_nib = a_reg[7:4];   b_nib = b_reg[7:4];   end
      2'd2: begin a_nib = a_reg[11:8];  b_nib = b_reg[11:8];  end
      default: begin a_nib = a_reg[15:12]; b_nib = b_reg[15:12]; end
    endcase
    // Nibble 0 takes op directly (the +1 of two's complement for subtract);
    // later nibbles chain the carry left by the previous pass.
    slice_cin = (nib_cnt == 2'd0) ? op_reg : carry_reg;
  end

  addsub4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .sub  (op_reg),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout),
    .ovf  (slice_ovf)
  );

  // Controller and all registered outputs. Operands are latched on accept so
  // the inputs may change freely while the operation runs. nib_cnt is parked
  // at 0 when leaving RUN, so there is never a fifth pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= 16'h0000;
      b_reg     <= 16'h0000;
      op_reg    <= 1'b0;
      nib_cnt   <= 2'd0;
      carry_reg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 16'h0000;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            nib_cnt   <= 2'd0;
            carry_reg <= op;
            result    <= 16'h0000;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          case (nib_cnt)
            2'd0:    result[3:0]   <= slice_sum;
            2'd1:    result[7:4]   <= slice_sum;
            2'd2:    result[11:8]  <= slice_sum;
            default: result[15:12] <= slice_sum;
          endcase
          carry_reg <= slice_cout;
          if (nib_cnt == 2'd3) begin
            carry_out <= slice_cout;
            overflow  <= slice_ovf;
            nib_cnt   <= 2'd0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            nib_cnt <= nib_cnt + 2'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub16_ctrl.sv
// Testbench for serial_addsub16_ctrl: directed operations with literal
// expectations, plus a per-cycle comparison against a behavioural model that
// tracks each operation by its age in cycles since acceptance.
module tb_serial_addsub16_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;

  int check_count = 0;
  int error_count = 0;

  serial_addsub16_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Arithmetic reference functions
  function automatic logic [15:0] modelResult(input logic [15:0] x, input logic [15:0] y,
                                              input logic sub);
    return sub ? (x - y) : (x + y);
  endfunction

  function automatic logic modelCarry(input logic [15:0] x, input logic [15:0] y,
                                      input logic sub);
    int s;
    s = int'(x) + int'(y);
    return sub ? (x >= y) : (s > 65535);
  endfunction

  function automatic logic modelOverflow(input logic [15:0] x, input logic [15:0] y,
                                         input logic sub);
    int sx;
    int sy;
    int sr;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = sub ? (sx - sy) : (sx + sy);
    return (sr > 32767) || (sr < -32768);
  endfunction

  function automatic logic [15:0] nibbleMask(input int n);
    logic [31:0] m;
    m = (32'h1 << (4 * n)) - 32'h1;
    return m[15:0];
  endfunction

  // Behavioural model: an accepted operation exposes n correct low nibbles
  // n edges later, completes at age 4 and is idle again at age 5.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_result = 16'h0000;
  logic        m_cout = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_full = 16'h0000;
  logic        m_fc = 1'b0;
  logic        m_fv = 1'b0;
  int          m_age = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= 16'h0000;
      m_cout   <= 1'b0;
      m_ovf    <= 1'b0;
      m_age    <= 0;
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (m_age < 4) m_result <= m_full & nibbleMask(m_age + 1);
      if (m_age == 3) begin
        m_done <= 1'b1;
        m_cout <= m_fc;
        m_ovf  <= m_fv;
      end
      if (m_age == 4) begin
        m_done <= 1'b0;
        m_busy <= 1'b0;
      end
    end else if (start) begin
      m_full   <= modelResult(a, b, op);
      m_fc     <= modelCarry(a, b, op);
      m_fv     <= modelOverflow(a, b, op);
      m_busy   <= 1'b1;
      m_age    <= 0;
      m_result <= 16'h0000;
      m_cout   <= 1'b0;
      m_ovf    <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    checkOutput("model busy", 32'(busy), 32'(m_busy));
    checkOutput("model done", 32'(done), 32'(m_done));
    checkOutput("model result", 32'(result), 32'(m_result));
    checkOutput("model carry_out", 32'(carry_out), 32'(m_cout));
    checkOutput("model overflow", 32'(overflow), 32'(m_ovf));
  end

  // Present one start pulse; returns in the cycle after the accepting edge.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic opv);
    @(negedge clk);
    a     = av;
    b     = bv;
    op    = opv;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges until done is seen; -1 when the bound expires.
  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = k;
        break;
      end
    end
    if (cycles < 0) begin
      error_count++;
      check_count++;
      $display("[TB] FAIL done timeout: got no done, expected done within 12 cycles");
    end
  endtask

  task automatic runOp(input string name, input logic [15:0] av, input logic [15:0] bv,
                       input logic opv, input logic [15:0] er, input logic ec, input logic ev);
    int cyc;
    applyStimulus(av, bv, opv);
    waitDone(cyc);
    checkOutput({name, " latency"}, 32'(cyc), 32'd4);
    checkOutput({name, " result"}, 32'(result), 32'(er));
    checkOutput({name, " carry_out"}, 32'(carry_out), 32'(ec));
    checkOutput({name, " overflow"}, 32'(overflow), 32'(ev));
    @(posedge clk);
    #1;
    checkOutput({name, " done after"}, 32'(done), 32'd0);
    checkOutput({name, " held result"}, 32'(result), 32'(er));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int done_times[$];
    int pulses;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset carry_out", 32'(carry_out), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Directed arithmetic
    runOp("add no carry", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    runOp("add wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    runOp("add ovf",      16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    runOp("sub ovf",      16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    runOp("sub borrow",   16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    runOp("sub plain",    16'h5000, 16'h1000, 1'b1, 16'h4000, 1'b1, 1'b0);

    // Start during RUN is ignored; operand changes during RUN have no effect
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    a     = 16'h00FF;
    b     = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 16'hAAAA;
    b     = 16'h5555;
    op    = 1'b1;
    waitDone(cyc);
    checkOutput("ignored start result", 32'(result), 32'h0002);
    checkOutput("ignored start carry_out", 32'(carry_out), 32'd0);
    repeat (3) @(negedge clk);

    // Start held high: back-to-back operations every 6 cycles
    a     = 16'h0010;
    b     = 16'h0020;
    op    = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_times.push_back(i);
        checkOutput("b2b result", 32'(result), 32'h0030);
      end
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b pulse count", 32'(done_times.size()), 32'd3);
    if (done_times.size() == 3) begin
      checkOutput("b2b first done", 32'(done_times[0]), 32'd4);
      checkOutput("b2b spacing 1", 32'(done_times[1] - done_times[0]), 32'd6);
      checkOutput("b2b spacing 2", 32'(done_times[2] - done_times[1]), 32'd6);
    end
    repeat (8) @(negedge clk);

    // Reset in the second RUN cycle aborts the operation
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checkOutput("abort no done", 32'(pulses), 32'd0);
    runOp("after abort", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
